// File: rtl/gcd_scheduler.sv
// gcd_scheduler: round-robin arbiter that time-shares one iterative GCD core
// between two req/ack requesters. Zero operands are answered locally; a core
// job that does not finish within TIMEOUT wait cycles is aborted with err=1.
module gcd_scheduler #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_req0,
    input  logic [WIDTH-1:0] i_a0,
    input  logic [WIDTH-1:0] i_b0,
    input  logic             i_req1,
    input  logic [WIDTH-1:0] i_a1,
    input  logic [WIDTH-1:0] i_b1,
    output logic             o_ack0,
    output logic [WIDTH-1:0] o_res0,
    output logic             o_err0,
    output logic             o_ack1,
    output logic [WIDTH-1:0] o_res1,
    output logic             o_err1,
    output logic             o_busy,
    output logic             o_core_start,
    output logic [WIDTH-1:0] o_core_num0,
    output logic [WIDTH-1:0] o_core_num1,
    input  logic             i_core_done,
    input  logic [WIDTH-1:0] i_core_result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESPOND
    } state_t;

    // Timer value seen during the last permitted WAIT cycle.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_owner;
    logic             w_owner;
    logic             r_last_served;
    logic             w_last_served;
    logic [7:0]       r_timer;
    logic [7:0]       w_timer;
    logic [WIDTH-1:0] w_num0;
    logic [WIDTH-1:0] w_num1;
    logic [WIDTH-1:0] w_result;
    logic             w_err;
    logic             w_respond;

    // Next-state decode plus the next value of every registered output.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
        w_next_state  = r_state;
        w_owner       = r_owner;
        w_last_served = r_last_served;
        w_timer       = r_timer;
        w_num0        = o_core_num0;
        w_num1        = o_core_num1;
        w_result      = '0;
        w_err         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_req0 || i_req1) begin
                    // Contention goes to whoever was not served last.
                    w_owner = (i_req0 && i_req1) ? ~r_last_served : i_req1;
                    w_num0  = w_owner ? i_a1 : i_a0;
                    w_num1  = w_owner ? i_b1 : i_b0;
                    if (w_num0 == '0 || w_num1 == '0) begin
                        // gcd(0,x) = x, and gcd(0,0) falls out as 0.
                        w_result     = (w_num0 == '0) ? w_num1 : w_num0;
                        w_next_state = S_RESPOND;
                    end else begin
                        w_next_state = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                w_timer      = '0;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                // Done is checked first so it wins over a same-edge timeout.
                if (i_core_done) begin
                    w_result     = i_core_result;
                    w_next_state = S_RESPOND;
                end else if (r_timer == TIMER_LAST) begin
                    w_err        = 1'b1;
                    w_next_state = S_RESPOND;
                end else if (r_timer != 8'hFF) begin
                    w_timer = r_timer + 8'd1;
                end
            end
            S_RESPOND: begin
                w_last_served = r_owner;
                w_next_state  = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase

        w_respond = (w_next_state == S_RESPOND);
    end

    // FSM state register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Control and output registers, loaded from the next-state decode so each
    // output lines up with the state it belongs to.
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_owner       <= 1'b0;
            r_last_served <= 1'b1;
            r_timer       <= '0;
            o_busy        <= 1'b0;
            o_core_start  <= 1'b0;
            o_core_num0   <= '0;
            o_core_num1   <= '0;
            o_ack0        <= 1'b0;
            o_res0        <= '0;
            o_err0        <= 1'b0;
            o_ack1        <= 1'b0;
            o_res1        <= '0;
            o_err1        <= 1'b0;
        end else begin
            r_owner       <= w_owner;
            r_last_served <= w_last_served;
            r_timer       <= w_timer;
            o_busy        <= (w_next_state != S_IDLE);
            o_core_start  <= (w_next_state == S_ISSUE);
            o_core_num0   <= w_num0;
            o_core_num1   <= w_num1;
            o_ack0        <= w_respond && !w_owner;
            o_ack1        <= w_respond && w_owner;
            if (w_respond && !w_owner) begin
                o_res0 <= w_result;
                o_err0 <= w_err;
            end
            if (w_respond && w_owner) begin
                o_res1 <= w_result;
                o_err1 <= w_err;
            end
        end
    end

endmodule

// File: tb/tb_gcd_scheduler.sv
// Directed bench for gcd_scheduler with a small behavioural GCD core whose
// response latency is set per scenario. Instance uses TIMEOUT=4.
module tb_gcd_scheduler;

    logic       clk;
    logic       rst;
    logic       req0, req1;
    logic [7:0] a0, b0, a1, b1;
    logic       ack0, ack1, err0, err1, busy, core_start, core_done;
    logic [7:0] res0, res1, core_num0, core_num1, core_result;

    int n_checks = 0;
    int n_pass   = 0;

    // Core model controls and observations.
    int         core_lat    = 1;   // WAIT cycle in which done is high; 0 = never
    bit         stale_issue = 0;   // raise a bogus done during ISSUE
    int         start_count = 0;
    logic [7:0] last_num0, last_num1, pend_res;

    // Two-requester job tables and results of run_both.
    logic [7:0] ja[2][4];
    logic [7:0] jb[2][4];
    int         ord_q[$];
    int         cyc_q[$];
    logic [7:0] res_q[$];

    gcd_scheduler #(.WIDTH(8), .TIMEOUT(4)) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_req0       (req0),
        .i_a0         (a0),
        .i_b0         (b0),
        .i_req1       (req1),
        .i_a1         (a1),
        .i_b1         (b1),
        .o_ack0       (ack0),
        .o_res0       (res0),
        .o_err0       (err0),
        .o_ack1       (ack1),
        .o_res1       (res1),
        .o_err1       (err1),
        .o_busy       (busy),
        .o_core_start (core_start),
        .o_core_num0  (core_num0),
        .o_core_num1  (core_num1),
        .i_core_done  (core_done),
        .i_core_result(core_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gcd8(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] t;
        while (y != 0) begin
            t = y;
            y = x % y;
            x = t;
        end
        return x;
    endfunction

    // Behavioural GCD core, acting just after each rising edge.
    initial begin
        int cnt;
        cnt = 0;
        core_done   = 1'b0;
        core_result = '0;
        forever begin
            @(posedge clk);
            #1;
            core_done = 1'b0;
            if (rst) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        core_done   = 1'b1;
                        core_result = pend_res;
                    end
                end
                if (core_start) begin
                    start_count++;
                    last_num0 = core_num0;
                    last_num1 = core_num1;
                    pend_res  = gcd8(core_num0, core_num1);
                    cnt       = core_lat;
                    if (stale_issue) begin
                        core_done   = 1'b1;
                        core_result = 8'hEE;
                    end
                end
            end
        end
    end

    task automatic set_req(input int r, input logic on, input logic [7:0] a, input logic [7:0] b);
        if (r == 0) begin
            req0 = on; a0 = a; b0 = b;
        end else begin
            req1 = on; a1 = a; b1 = b;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One requester, one job: returns ack cycle (1 = cycle after the grant edge, 0 = none).
    task automatic serve(input int who, input logic [7:0] a, input logic [7:0] b,
                         output int cyc, output logic [7:0] res, output logic err,
                         output bit other_ack, output bit busy_ack, output int starts);
        int s0;
        @(negedge clk);
        s0 = start_count;
        set_req(who, 1'b1, a, b);
        cyc = 0; res = 'x; err = 1'bx; other_ack = 0; busy_ack = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if ((who == 0) ? ack1 : ack0) other_ack = 1;
            if ((who == 0) ? ack0 : ack1) begin
                cyc      = c;
                res      = (who == 0) ? res0 : res1;
                err      = (who == 0) ? err0 : err1;
                busy_ack = busy;
                break;
            end
        end
        set_req(who, 1'b0, 8'd0, 8'd0);
        starts = start_count - s0;
    endtask

    // Both requesters work through their job tables; each re-raises req in the
    // IDLE cycle after its own ack while jobs remain.
    task automatic run_both(input int n0, input int n1);
        int left[2];
        int idx[2];
        bit raise[2];
        left[0] = n0; left[1] = n1;
        idx[0] = 0; idx[1] = 0;
        raise[0] = 0; raise[1] = 0;
        ord_q.delete(); cyc_q.delete(); res_q.delete();
        @(negedge clk);
        for (int r = 0; r < 2; r++)
            if (left[r] > 0) set_req(r, 1'b1, ja[r][0], jb[r][0]);
        for (int c = 1; c <= 200 && (left[0] > 0 || left[1] > 0); c++) begin
            @(negedge clk);
            for (int r = 0; r < 2; r++) begin
                if (raise[r]) begin
                    set_req(r, 1'b1, ja[r][idx[r]], jb[r][idx[r]]);
                    raise[r] = 0;
                end else if ((r == 0) ? ack0 : ack1) begin
                    ord_q.push_back(r);
                    cyc_q.push_back(c);
                    res_q.push_back((r == 0) ? res0 : res1);
                    idx[r]++;
                    left[r]--;
                    set_req(r, 1'b0, 8'd0, 8'd0);
                    raise[r] = (left[r] > 0);
                end
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if ({ack0, ack1, err0, err1, busy, core_start} !== 6'b0)
            $display("FAIL reset_ctrl: got %b expected 000000", {ack0, ack1, err0, err1, busy, core_start}); else n_pass++;
        n_checks++; if ({res0, res1, core_num0, core_num1} !== 32'h0)
            $display("FAIL reset_data: got %h expected 00000000", {res0, res1, core_num0, core_num1}); else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (start_count !== 0) $display("FAIL reset_no_start: got %0d expected 0", start_count); else n_pass++;
    endtask

    task automatic test_single();
        int cyc, starts; logic [7:0] res; logic err; bit oth, bz;
        core_lat = 2;
        serve(0, 8'd48, 8'd18, cyc, res, err, oth, bz, starts);
        n_checks++; if (cyc !== 4) $display("FAIL single_latency: got %0d expected 4", cyc); else n_pass++;
        n_checks++; if (res !== 8'd6) $display("FAIL single_res: got %0d expected 6", res); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL single_err: got %b expected 0", err); else n_pass++;
        n_checks++; if (oth !== 1'b0) $display("FAIL single_ack1: got %b expected 0", oth); else n_pass++;
        n_checks++; if (starts !== 1) $display("FAIL single_starts: got %0d expected 1", starts); else n_pass++;
        n_checks++; if ({last_num0, last_num1} !== {8'd48, 8'd18})
            $display("FAIL single_nums: got %0d,%0d expected 48,18", last_num0, last_num1); else n_pass++;
        n_checks++; if (bz !== 1'b1) $display("FAIL single_busy_respond: got %b expected 1", bz); else n_pass++;
        @(negedge clk);
        n_checks++; if ({ack0, busy} !== 2'b00) $display("FAIL single_after: got ack0,busy=%b expected 00", {ack0, busy}); else n_pass++;
        n_checks++; if (res0 !== 8'd6) $display("FAIL single_res_hold: got %0d expected 6", res0); else n_pass++;
    endtask

    task automatic test_zero();
        int cyc, starts; logic [7:0] res; logic err; bit oth, bz;
        serve(1, 8'd0, 8'd35, cyc, res, err, oth, bz, starts);
        n_checks++; if (cyc !== 1) $display("FAIL zero_latency: got %0d expected 1", cyc); else n_pass++;
        n_checks++; if (res !== 8'd35) $display("FAIL zero_res: got %0d expected 35", res); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL zero_err: got %b expected 0", err); else n_pass++;
        n_checks++; if (starts !== 0) $display("FAIL zero_no_start: got %0d expected 0", starts); else n_pass++;
        n_checks++; if (oth !== 1'b0) $display("FAIL zero_ack0: got %b expected 0", oth); else n_pass++;
        serve(1, 8'd0, 8'd0, cyc, res, err, oth, bz, starts);
        n_checks++; if (res !== 8'd0 || cyc !== 1)
            $display("FAIL zero_both: got res %0d cyc %0d expected res 0 cyc 1", res, cyc); else n_pass++;
        n_checks++; if (res0 !== 8'd6) $display("FAIL zero_res0_hold: got %0d expected 6", res0); else n_pass++;
    endtask

    task automatic test_simultaneous();
        apply_reset();
        core_lat = 1;
        ja[0][0] = 8'd12; jb[0][0] = 8'd8;
        ja[1][0] = 8'd9;  jb[1][0] = 8'd6;
        for (int pass = 0; pass < 2; pass++) begin
            run_both(1, 1);
            n_checks++; if (ord_q.size() !== 2) $display("FAIL simul_count pass%0d: got %0d expected 2", pass, ord_q.size()); else n_pass++;
            if (ord_q.size() == 2) begin
                n_checks++; if (ord_q[0] !== 0 || ord_q[1] !== 1)
                    $display("FAIL simul_order pass%0d: got %0d,%0d expected 0,1", pass, ord_q[0], ord_q[1]); else n_pass++;
                n_checks++; if (res_q[0] !== 8'd4 || res_q[1] !== 8'd3)
                    $display("FAIL simul_res pass%0d: got %0d,%0d expected 4,3", pass, res_q[0], res_q[1]); else n_pass++;
                n_checks++; if (cyc_q[0] !== 3 || cyc_q[1] !== 7)
                    $display("FAIL simul_cycles pass%0d: got %0d,%0d expected 3,7", pass, cyc_q[0], cyc_q[1]); else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        core_lat = 1;
        ja[0][0] = 8'd12; jb[0][0] = 8'd8;
        ja[0][1] = 8'd21; jb[0][1] = 8'd14;
        ja[1][0] = 8'd9;  jb[1][0] = 8'd6;
        ja[1][1] = 8'd35; jb[1][1] = 8'd25;
        run_both(2, 2);
        n_checks++; if (ord_q.size() !== 4) $display("FAIL b2b_count: got %0d expected 4", ord_q.size()); else n_pass++;
        if (ord_q.size() == 4) begin
            n_checks++; if ({ord_q[0][0], ord_q[1][0], ord_q[2][0], ord_q[3][0]} !== 4'b0101)
                $display("FAIL b2b_order: got %0d%0d%0d%0d expected 0101", ord_q[0], ord_q[1], ord_q[2], ord_q[3]); else n_pass++;
            n_checks++; if ({res_q[0], res_q[1], res_q[2], res_q[3]} !== {8'd4, 8'd3, 8'd7, 8'd5})
                $display("FAIL b2b_res: got %0d,%0d,%0d,%0d expected 4,3,7,5", res_q[0], res_q[1], res_q[2], res_q[3]); else n_pass++;
            n_checks++; if (cyc_q[0] !== 3 || cyc_q[1] !== 7 || cyc_q[2] !== 11 || cyc_q[3] !== 15)
                $display("FAIL b2b_cycles: got %0d,%0d,%0d,%0d expected 3,7,11,15", cyc_q[0], cyc_q[1], cyc_q[2], cyc_q[3]); else n_pass++;
        end
    endtask

    task automatic test_timeout();
        int cyc, starts; logic [7:0] res; logic err; bit oth, bz;
        core_lat = 0;
        serve(0, 8'd40, 8'd30, cyc, res, err, oth, bz, starts);
        n_checks++; if (cyc !== 6) $display("FAIL timeout_latency: got %0d expected 6", cyc); else n_pass++;
        n_checks++; if (err !== 1'b1 || res !== 8'd0)
            $display("FAIL timeout_flag: got err %b res %0d expected err 1 res 0", err, res); else n_pass++;
        n_checks++; if (starts !== 1) $display("FAIL timeout_starts: got %0d expected 1", starts); else n_pass++;
        core_lat = 1;
        serve(0, 8'd40, 8'd30, cyc, res, err, oth, bz, starts);
        n_checks++; if (err !== 1'b0 || res !== 8'd10 || cyc !== 3)
            $display("FAIL timeout_recover: got err %b res %0d cyc %0d expected err 0 res 10 cyc 3", err, res, cyc); else n_pass++;
        core_lat = 0;
        stale_issue = 1;
        serve(0, 8'd40, 8'd30, cyc, res, err, oth, bz, starts);
        stale_issue = 0;
        n_checks++; if (err !== 1'b1 || res !== 8'd0 || cyc !== 6)
            $display("FAIL stale_done_issue: got err %b res %0d cyc %0d expected err 1 res 0 cyc 6", err, res, cyc); else n_pass++;
    endtask

    task automatic test_collision();
        int cyc, starts; logic [7:0] res; logic err; bit oth, bz;
        core_lat = 4;
        serve(1, 8'd15, 8'd10, cyc, res, err, oth, bz, starts);
        n_checks++; if (cyc !== 6 || err !== 1'b0 || res !== 8'd5)
            $display("FAIL collision: got cyc %0d err %b res %0d expected cyc 6 err 0 res 5", cyc, err, res); else n_pass++;
        core_lat = 3;
        serve(1, 8'd27, 8'd18, cyc, res, err, oth, bz, starts);
        n_checks++; if (cyc !== 5 || err !== 1'b0 || res !== 8'd9)
            $display("FAIL late_done: got cyc %0d err %b res %0d expected cyc 5 err 0 res 9", cyc, err, res); else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        int s0, cyc;
        bit seen_start, stray_ack;
        core_lat = 0;
        @(negedge clk);
        set_req(0, 1'b1, 8'd20, 8'd8);
        seen_start = 0;
        for (int c = 0; c < 10 && !seen_start; c++) begin
            @(negedge clk);
            seen_start = core_start;
        end
        n_checks++; if (!seen_start) $display("FAIL rst_wait_start: got 0 expected 1"); else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if ({ack0, ack1, err0, err1, busy, core_start} !== 6'b0 ||
                        {res0, res1, core_num0, core_num1} !== 32'h0)
            $display("FAIL rst_wait_outputs: got %b/%h expected all 0",
                     {ack0, ack1, err0, err1, busy, core_start}, {res0, res1, core_num0, core_num1}); else n_pass++;
        stray_ack = 0;
        repeat (2) begin
            @(negedge clk);
            if (ack0 || ack1) stray_ack = 1;
        end
        core_lat = 1;
        s0 = start_count;
        rst = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (ack0) begin
                cyc = c;
                break;
            end
        end
        n_checks++; if (stray_ack) $display("FAIL rst_wait_no_ack: got 1 expected 0"); else n_pass++;
        n_checks++; if (cyc !== 3 || res0 !== 8'd4 || err0 !== 1'b0)
            $display("FAIL rst_wait_reserve: got cyc %0d res %0d err %b expected cyc 3 res 4 err 0", cyc, res0, err0); else n_pass++;
        n_checks++; if (start_count - s0 !== 1)
            $display("FAIL rst_wait_fresh_start: got %0d expected 1", start_count - s0); else n_pass++;
        set_req(0, 1'b0, 8'd0, 8'd0);
    endtask

    initial begin
        rst  = 1'b1;
        req0 = 1'b0; a0 = '0; b0 = '0;
        req1 = 1'b0; a1 = '0; b1 = '0;
        test_reset();
        test_single();
        test_zero();
        test_simultaneous();
        test_back_to_back();
        test_timeout();
        test_collision();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gcd_scheduler.md
# gcd_scheduler

Round-robin controller that shares one iterative GCD core between two requesters. Each requester presents an operand pair under a req/ack handshake. The scheduler grants one request at a time and drives the core's start pulse and operands. It then waits for the core's done flag, with a timeout, and returns the result and an error flag to the granted requester. Zero operands are resolved locally without using the core.

## Interface
- WIDTH, 8, operand/result width
- TIMEOUT, 255, max WAIT cycles before abort (1..255, 8-bit timer)

- _clock  in  1  rising-edge clock
- _reset  in  1  asynchronous, active-high reset
- _req0 / _req1  in  1  request from requester 0 / 1
- _a0, _b0 / _a1, _b1  in  WIDTH  operand pair of requester 0 / 1; stable while req high
- _ack0 / _ack1  out  1  one-cycle completion strobe, registered
- _res0 / _res1  out  WIDTH  result, registered; updated only with own ack, held otherwise
- _err0 / _err1  out  1  timeout flag, registered; updated only with own ack, held otherwise
- _busy  out  1  high in any state other than IDLE
- _core_start  out  1  one-cycle start pulse to GCD core
- _core_num0, _core_num1  out  WIDTH  core operands; held from ISSUE through WAIT
- _core_done  in  1  core completion; sampled only in WAIT
- _core_result  in  WIDTH  core result; valid with _core_done

## Operation
- States: IDLE, ISSUE, WAIT, RESPOND. State is registered, and all outputs are registered.
- IDLE
  - No req high: stay in IDLE.
  - One req high: grant that requester.
  - Both high: grant the requester that is not the last-served one. After reset, requester 0 wins.
  - On grant: latch the operand pair and the owner index.
  - Either latched operand is 0: result = other operand (gcd(0,0)=0), err=0, go to RESPOND.
  - Otherwise: go to ISSUE.
- ISSUE
  - _core_start=1 for this cycle only.
  - _core_num0/_core_num1 = latched operands.
  - Clear timer; go to WAIT.
- WAIT
  - _core_done sampled high: capture _core_result, err=0, go to RESPOND.
  - Otherwise: timer+1. When timer reaches TIMEOUT: result=0, err=1, go to RESPOND.
  - Done and timeout on the same edge: done wins.
- RESPOND
  - _ackN=1 for the owner only; _resN/_errN are updated on the same edge.
  - Last-served pointer = owner; go to IDLE.
- Handshake rules
  - The requester holds req and operands until it samples ack high.
  - It drops req on that same edge, so req is low in the IDLE cycle after ack.
  - A req sampled high in IDLE is always a new request.
  - A non-owner's req stays pending through the whole transaction; it is not lost.
- Outputs in IDLE: _core_start=0. _core_num0/_core_num1 hold their last values and are don't-care.
- Width rules: all data paths are WIDTH bits; no arithmetic beyond the timer increment. The timer saturates and never wraps.

## Timing
- Reset (async assert, sync release):
  - State=IDLE, last-served=1 so requester 0 has first priority, timer=0.
  - All outputs are 0: _ack*, _res*, _err*, _busy, _core_start, _core_num*.
- Reset mid-operation aborts the transaction: no ack, no further start pulse.
- Latency, with E0 = edge where IDLE samples req:
  - Zero-operand request: ack high in the cycle after E0 (1 cycle).
  - Core request: start high in cycle after E0. WAIT begins after E1.
  - If done is sampled at edge Ed: ack high in the cycle after Ed. Minimum 3 cycles, when done is seen in the first WAIT cycle.
  - Timeout: ack in the cycle after the TIMEOUT-th WAIT cycle.
- Throughput: the cycle after RESPOND is always IDLE. With both requesters continuously active, service strictly alternates 0,1,0,1.
- _busy = 1 from the cycle after E0 through the RESPOND cycle inclusive.
- _core_done outside WAIT is ignored, including a stale done during ISSUE.

## Test plan
- Single request: _req0, a0=48, b0=18; core model returns 6 two cycles after start.
  - Expect exactly one _core_start pulse with num0=48, num1=18.
  - Expect _ack0 one cycle with _res0=6 and _err0=0; _ack1 never asserts.
- Zero operand: _req1, a1=0, b1=35.
  - Expect no _core_start.
  - Expect _ack1 in the cycle after the grant with _res1=35.
  - Repeat with 0,0: expect _res1=0.
- Simultaneous requests: both reqs from reset, (12,8) and (9,6), each held until its own ack.
  - Requester 0 is served first (res 4), then requester 1 (res 3).
  - Repeat the pair: requester 0 again first, because last-served=1.
- Timeout: TIMEOUT=4; core never asserts done.
  - Expect _ack0 after 4 WAIT cycles with _err0=1 and _res0=0.
  - Next request with a done-returning core gives _err0=0.
- Done/timeout collision: done asserted exactly on the TIMEOUT-th WAIT cycle -> err=0, result = core result.
- Reset mid-WAIT: assert _reset during WAIT.
  - All outputs read 0 immediately (async) and the state returns to IDLE.
  - No ack is produced; a request held after release is re-served with a fresh start pulse.
